vend_credit_fsm: RTL

//  Upstream credit stage of the vending datapath. Accumulates inserted coins into a

---
 rtl/vend_credit_fsm.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vend_credit_fsm.sv
// vend_credit_fsm: coin credit accumulator and vend sequencer feeding an external comparator.
// Optional idle auto-refund is compiled in by defining TIMEOUT_EN.
module vend_credit_fsm #(
    parameter int WIDTH     = 4,
    parameter int COIN0_VAL = 1,
    parameter int COIN1_VAL = 2,
    parameter int COIN2_VAL = 5
`ifdef TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    input  logic             sel_valid,
    input  logic [WIDTH-1:0] price,
    input  logic             cancel,
    input  logic             a_gte_b,
    output logic [WIDTH-1:0] credit,
    output logic [WIDTH-1:0] price_q,
    output logic             dispense,
    output logic             change_valid,
    output logic [WIDTH-1:0] change,
    output logic             coin_reject,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    // Handshake: every input is a one-cycle strobe consumed in the cycle it is high
    // (no ready/back-pressure); outputs are registered one-cycle pulses.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_COLLECT  = 3'd1;
    localparam logic [2:0] ST_CHECK    = 3'd2;
    localparam logic [2:0] ST_DISPENSE = 3'd3;
    localparam logic [2:0] ST_CHANGE   = 3'd4;

    logic [2:0]     state;
    logic [WIDTH:0] coin_val;
    logic           coin_bad;
    logic [WIDTH:0] coin_sum;
    logic           coin_fits;
    logic           timeout_hit;

    assign state_dbg = state;

    always_comb begin
        coin_val = '0;
        coin_bad = 1'b0;
        case (coin_type)
            2'b00:   coin_val = (WIDTH+1)'(COIN0_VAL);
            2'b01:   coin_val = (WIDTH+1)'(COIN1_VAL);
            2'b10:   coin_val = (WIDTH+1)'(COIN2_VAL);
            default: coin_bad = 1'b1;
        endcase
    end

    // One extra bit so an overflowing coin is detected instead of wrapping credit.
    assign coin_sum  = {1'b0, credit} + coin_val;
    assign coin_fits = !coin_bad && !coin_sum[WIDTH];

`ifdef TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             activity;

    assign activity    = coin_valid || sel_valid || cancel;
    assign timeout_hit = (state == ST_COLLECT) && !activity &&
                         (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != ST_COLLECT || activity || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            credit       <= '0;
            price_q      <= '0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change       <= '0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        price_q     <= price;
                        coin_reject <= coin_valid;
                    end else if (coin_valid) begin
                        if (coin_fits) begin
                            credit <= coin_sum[WIDTH-1:0];
                            state  <= ST_COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (cancel || timeout_hit) begin
                        state        <= ST_CHANGE;
                        change_valid <= 1'b1;
                        change       <= credit;
                        busy         <= 1'b1;
                        coin_reject  <= coin_valid;
                    end else if (sel_valid) begin
                        price_q     <= price;
                        state       <= ST_CHECK;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end else if (coin_valid) begin
                        if (coin_fits) begin
                            credit <= coin_sum[WIDTH-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                // The comparator already sees the freshly latched price_q here.
                ST_CHECK: begin
                    coin_reject <= coin_valid;
                    if (a_gte_b) begin
                        state    <= ST_DISPENSE;
                        dispense <= 1'b1;
                    end else begin
                        state <= ST_COLLECT;
                        busy  <= 1'b0;
                    end
                end
                ST_DISPENSE: begin
                    coin_reject  <= coin_valid;
                    state        <= ST_CHANGE;
                    change_valid <= 1'b1;
                    change       <= credit - price_q;
                end
                ST_CHANGE: begin
                    coin_reject <= coin_valid;
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    credit      <= '0;
                    price_q     <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
